sti_unpack_loader: RTL and testbench



---
 rtl/dt_pkg.sv | 24 ++
 rtl/sti_word_shifter.sv | 35 +++
 rtl/sti_unpack_loader.sv | 136 +++++++++++++
 tb/tb_sti_unpack_loader.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dt_pkg.sv
// Shared constants and types for the distance-transform datapath.
// Image geometry, memory address widths, pixel values and the loader FSM state type.
package dt_pkg;

    localparam int IMG_W        = 128;
    localparam int IMG_H        = 128;
    localparam int N_PIX        = IMG_W * IMG_H;
    localparam int STI_AW       = 10;
    localparam int RES_AW       = 14;
    localparam int PIX_W        = 8;
    localparam int N_WORDS      = 1024;
    localparam int PIX_PER_WORD = 16;

    localparam logic [PIX_W-1:0] OBJ_VAL = 8'h01;
    localparam logic [PIX_W-1:0] BG_VAL  = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_WRITE  = 2'd2,
        ST_FINISH = 2'd3
    } loader_state_t;

endpackage

// File: rtl/sti_word_shifter.sv
// Holds the current 16-bit ROM word and the pixel index inside it (MSB first).
// Exposes the pixel bit being written this cycle and a flag for the last pixel of the word.
module sti_word_shifter
    import dt_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_load,
    input  logic                    i_adv,
    input  logic [PIX_PER_WORD-1:0] i_word,
    output logic                    o_bit,
    output logic                    o_last,
    output logic [3:0]              o_k
);

    logic [PIX_PER_WORD-1:0] r_word;
    logic [3:0]              r_k;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_word <= '0;
            r_k    <= 4'd0;
        end else if (i_load) begin
            r_word <= i_word;
            r_k    <= 4'd0;
        end else if (i_adv) begin
            r_k    <= r_k + 4'd1;
        end
    end

    assign o_bit  = r_word[4'd15 - r_k];
    assign o_last = (r_k == 4'd15);
    assign o_k    = r_k;

endmodule

// File: rtl/sti_unpack_loader.sv
// Unpacks the 1-bpp 128x128 stimulus image from ROM into the 8-bit result RAM and counts object pixels.
// Optional STI_BORDER_CLEAR_EN forces the outer image border to background.
module sti_unpack_loader
    import dt_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                sti_rd,
    output logic [STI_AW-1:0]   sti_addr,
    input  logic [15:0]         sti_di,
    output logic                res_wr,
    output logic [RES_AW-1:0]   res_addr,
    output logic [PIX_W-1:0]    res_do,
    output logic [14:0]         obj_cnt,
    output logic [1:0]          o_dbg_state
);

    // start is a one-cycle request honoured only in IDLE; busy spans FETCH..FINISH;
    // done pulses once, in FINISH, after the last pixel write has been issued.
    loader_state_t       r_state;
    logic                r_busy;
    logic                r_done;
    logic                r_sti_rd;
    logic                r_res_wr;
    logic [STI_AW-1:0]   r_sti_addr;
    logic [STI_AW-1:0]   r_w;
    logic [14:0]         r_obj_cnt;

    logic                w_bit;
    logic                w_last;
    logic [3:0]          w_k;
    logic                w_load;
    logic                w_adv;
    logic                w_last_word;
    logic                w_border;
    logic                w_pix;
    logic [RES_AW-1:0]   w_pix_addr;

    assign w_last_word = (r_w == STI_AW'(N_WORDS - 1));
    assign w_load      = (r_state == ST_FETCH) ||
                         ((r_state == ST_WRITE) && w_last && !w_last_word);
    assign w_adv       = (r_state == ST_WRITE) && !w_last;
    assign w_pix_addr  = {r_w, w_k};

`ifdef STI_BORDER_CLEAR_EN
    assign w_border = (w_pix_addr[13:7] == 7'd0) || (w_pix_addr[13:7] == 7'd127) ||
                      (w_pix_addr[6:0]  == 7'd0) || (w_pix_addr[6:0]  == 7'd127);
`else
    assign w_border = 1'b0;
`endif

    assign w_pix = w_bit && !w_border;

    sti_word_shifter u_shifter (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_load),
        .i_adv  (w_adv),
        .i_word (sti_di),
        .o_bit  (w_bit),
        .o_last (w_last),
        .o_k    (w_k)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_sti_rd   <= 1'b0;
            r_res_wr   <= 1'b0;
            r_sti_addr <= '0;
            r_w        <= '0;
            r_obj_cnt  <= '0;
        end else begin
            r_sti_rd <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state    <= ST_FETCH;
                        r_busy     <= 1'b1;
                        r_sti_rd   <= 1'b1;
                        r_sti_addr <= '0;
                        r_w        <= '0;
                        r_obj_cnt  <= '0;
                    end
                end
                ST_FETCH: begin
                    r_state  <= ST_WRITE;
                    r_res_wr <= 1'b1;
                end
                ST_WRITE: begin
                    if (w_pix) begin
                        r_obj_cnt <= r_obj_cnt + 15'd1;
                    end
                    // Read is issued one cycle ahead so the next word arrives exactly at the word boundary.
                    if ((w_k == 4'd14) && !w_last_word) begin
                        r_sti_rd   <= 1'b1;
                        r_sti_addr <= r_w + STI_AW'(1);
                    end
                    if (w_last) begin
                        if (w_last_word) begin
                            r_state  <= ST_FINISH;
                            r_res_wr <= 1'b0;
                            r_done   <= 1'b1;
                        end else begin
                            r_w <= r_w + STI_AW'(1);
                        end
                    end
                end
                ST_FINISH: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign sti_rd      = r_sti_rd;
    assign sti_addr    = r_sti_addr;
    assign res_wr      = r_res_wr;
    assign res_addr    = w_pix_addr;
    assign res_do      = (r_res_wr && w_pix) ? OBJ_VAL : BG_VAL;
    assign obj_cnt     = r_obj_cnt;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_sti_unpack_loader.sv
// Self-checking bench for sti_unpack_loader: ROM/RAM models, a timeline reference model and
// a per-cycle compare, plus directed image loads. Honours STI_BORDER_CLEAR_EN like the design.
module tb_sti_unpack_loader;

    localparam int          T_NPIX     = 16384;
    localparam int          T_LOAD_CYC = 16386;
    localparam logic [7:0]  T_OBJ      = 8'h01;

    logic        clk;
    logic        reset;
    logic        start;
    logic        busy;
    logic        done;
    logic        sti_rd;
    logic [9:0]  sti_addr;
    logic [15:0] sti_di;
    logic        res_wr;
    logic [13:0] res_addr;
    logic [7:0]  res_do;
    logic [14:0] obj_cnt;
    logic [1:0]  dbg_state;

    logic [15:0] rom [1024];
    logic [15:0] rom_q;
    logic [7:0]  ram [T_NPIX];
    int          wr_cnt [T_NPIX];
    int          rd_cnt;
    int          done_cnt;
    int          errors;
    int          checks;

    // Reference timeline: cycle 1 = fetch, 2..16385 = pixel writes, 16386 = done.
    int          m_cyc;
    int          m_obj;

    sti_unpack_loader dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .sti_rd      (sti_rd),
        .sti_addr    (sti_addr),
        .sti_di      (sti_di),
        .res_wr      (res_wr),
        .res_addr    (res_addr),
        .res_do      (res_do),
        .obj_cnt     (obj_cnt),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM registers its output on the falling edge.
    always @(negedge clk) begin
        if (sti_rd) rom_q <= rom[sti_addr];
    end
    assign sti_di = rom_q;

    function automatic bit pix(input int p);
        logic [15:0] wd;
        bit          b;
        wd = rom[p / 16];
        b  = wd[15 - (p % 16)];
`ifdef STI_BORDER_CLEAR_EN
        if ((p / 128) == 0 || (p / 128) == 127 || (p % 128) == 0 || (p % 128) == 127) b = 1'b0;
`endif
        return b;
    endfunction

    function automatic int count_obj();
        int n;
        n = 0;
        for (int p = 0; p < T_NPIX; p++) if (pix(p)) n++;
        return n;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_cyc <= 0;
            m_obj <= 0;
        end else if (m_cyc != 0) begin
            if (m_cyc >= 2 && m_cyc <= T_NPIX + 1 && pix(m_cyc - 2)) m_obj <= m_obj + 1;
            m_cyc <= (m_cyc == T_LOAD_CYC) ? 0 : m_cyc + 1;
        end else if (start) begin
            m_cyc <= 1;
            m_obj <= 0;
        end
    end

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic cycle_step();
        int          c;
        int          p;
        logic        e_busy, e_done, e_rd, e_wr;
        logic [9:0]  e_saddr;
        logic [13:0] e_raddr;
        logic [7:0]  e_do;
        bit          bad;
        if (res_wr) begin
            ram[res_addr]    = res_do;
            wr_cnt[res_addr] = wr_cnt[res_addr] + 1;
        end
        if (sti_rd) rd_cnt++;
        if (done) done_cnt++;

        c       = m_cyc;
        p       = c - 2;
        e_busy  = (c != 0);
        e_done  = (c == T_LOAD_CYC);
        e_wr    = (c >= 2 && c <= T_NPIX + 1);
        e_rd    = (c == 1) || (e_wr && (p % 16) == 15 && p != T_NPIX - 1);
        e_saddr = (c == 1) ? 10'd0 : 10'(p / 16 + 1);
        e_raddr = 14'(p);
        e_do    = 8'h00;
        if (e_wr && pix(p)) e_do = T_OBJ;

        bad = (busy !== e_busy) || (done !== e_done) || (sti_rd !== e_rd) ||
              (e_rd && sti_addr !== e_saddr) || (res_wr !== e_wr) ||
              (e_wr && (res_addr !== e_raddr || res_do !== e_do)) ||
              (obj_cnt !== 15'(m_obj));
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL cycle_cmp t=%0t c=%0d got busy=%b done=%b rd=%b saddr=%0d wr=%b raddr=%0d do=%h cnt=%0d expected busy=%b done=%b rd=%b saddr=%0d wr=%b raddr=%0d do=%h cnt=%0d",
                     $time, c, busy, done, sti_rd, sti_addr, res_wr, res_addr, res_do, obj_cnt,
                     e_busy, e_done, e_rd, e_saddr, e_wr, e_raddr, e_do, m_obj);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"},     busy,     0);
        check({tag, "_done"},     done,     0);
        check({tag, "_sti_rd"},   sti_rd,   0);
        check({tag, "_sti_addr"}, sti_addr, 0);
        check({tag, "_res_wr"},   res_wr,   0);
        check({tag, "_res_addr"}, res_addr, 0);
        check({tag, "_res_do"},   res_do,   0);
        check({tag, "_obj_cnt"},  obj_cnt,  0);
    endtask

    task automatic check_image(input string tag);
        int bad_val;
        int bad_cnt;
        bad_val = 0;
        bad_cnt = 0;
        for (int p = 0; p < T_NPIX; p++) begin
            if (ram[p] !== (pix(p) ? T_OBJ : 8'h00)) bad_val++;
            if (wr_cnt[p] != 1) bad_cnt++;
        end
        check({tag, "_ram_bad_pixels"}, bad_val, 0);
        check({tag, "_ram_not_written_once"}, bad_cnt, 0);
        check({tag, "_obj_cnt_total"}, obj_cnt, count_obj());
    endtask

    // ---------------- drivers ----------------
    task automatic fill_rom(input int kind);
        for (int i = 0; i < 1024; i++) begin
            case (kind)
                0: rom[i] = 16'h0000;
                1: case (i % 3)
                       0: rom[i] = 16'($urandom_range(0, 65535));
                       1: rom[i] = 16'($urandom_range(0, 65535) & $urandom_range(0, 65535));
                       default: rom[i] = 16'($urandom_range(0, 65535) | $urandom_range(0, 65535));
                   endcase
                2: rom[i] = 16'hFFFF;
                default: rom[i] = (i == 0) ? 16'h8001 : 16'h0000;
            endcase
        end
    endtask

    task automatic clear_ram();
        for (int p = 0; p < T_NPIX; p++) begin
            ram[p]    = 8'hAA;
            wr_cnt[p] = 0;
        end
    endtask

    task automatic run_load(input string tag, input bit poke_start);
        int lat;
        bit seen;
        clear_ram();
        rd_cnt   = 0;
        done_cnt = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat  = 1;
        seen = 1'b0;
        while (!seen && lat < 17000) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                start = (poke_start && lat == 100);
                @(negedge clk);
                lat++;
            end
        end
        start = 1'b0;
        check({tag, "_done_latency"}, seen ? lat : -1, T_LOAD_CYC);
        if (poke_start) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        repeat (20) @(negedge clk);
        check({tag, "_done_pulses"}, done_cnt, 1);
        check({tag, "_rd_cycles"}, rd_cnt, 1024);
        check({tag, "_idle_after"}, busy, 0);
    endtask

    task automatic abort_load();
        done_cnt = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4999) @(negedge clk);
        #1 reset = 1'b0;
        #1;
        check_outputs_zero("midload_reset");
        repeat (3) @(negedge clk);
        check("midload_no_done", done_cnt, 0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        errors   = 0;
        checks   = 0;
        rd_cnt   = 0;
        done_cnt = 0;
        reset    = 1'b0;
        start    = 1'b0;
        fill_rom(0);
        clear_ram();
        fork
            forever begin
                @(negedge clk);
                cycle_step();
            end
        join_none

        repeat (3) @(negedge clk);
        check_outputs_zero("reset_state");
        reset = 1'b1;
        repeat (2) @(negedge clk);

        fill_rom(0);
        run_load("zero", 1'b0);
        check_image("zero");
        check("zero_obj_cnt", obj_cnt, 0);

        fill_rom(1);
        abort_load();

        run_load("random", 1'b1);
        check_image("random");

        fill_rom(2);
        run_load("ones", 1'b0);
        check_image("ones");
`ifdef STI_BORDER_CLEAR_EN
        check("ones_obj_cnt", obj_cnt, 15876);
        check("ones_corner_pixel", ram[0], 0);
        check("ones_inner_pixel", ram[129], 1);
`else
        check("ones_obj_cnt", obj_cnt, 16384);
        check("ones_last_pixel", ram[16383], 1);
`endif

        fill_rom(3);
        run_load("w8001", 1'b0);
        check_image("w8001");
`ifdef STI_BORDER_CLEAR_EN
        check("w8001_ram0", ram[0], 0);
        check("w8001_ram15", ram[15], 0);
        check("w8001_obj_cnt", obj_cnt, 0);
`else
        check("w8001_ram0", ram[0], 1);
        check("w8001_ram15", ram[15], 1);
        check("w8001_obj_cnt", obj_cnt, 2);
`endif
        check("w8001_ram1", ram[1], 0);
        check("w8001_ram16", ram[16], 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
